booth_mult_pipe: RTL
====================

# booth_mult_pipe

Parametrised, pipelined radix-4 Booth multiplier with signed/unsigned mode per transaction and valid/ready flow control. Generates Booth partial products, reduces them to a sum/carry pair with a carry-save (3:2) tree, then resolves the product with a final carry-propagate add. It replaces the fixed-width hand-instanced compressor layers in Booth_Multi. It is the multiplier core for the datapath, feeding downstream accumulate/FIFO logic.

## Interface
- WIDTH, 16, operand width in bits; even, ≥ 4
- TAG_W, 4, width of sideband tag carried with each operation
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  stage 1 can accept this cycle
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_a  in  WIDTH  multiplicand
- in_b  in  WIDTH  multiplier (Booth-recoded)
- in_tag  in  TAG_W  sideband, returned unchanged with result
- out_valid  out  1  product available
- out_ready  in  1  consumer accepts product
- out_p  out  2*WIDTH  product (signed or unsigned per in_signed)
- out_tag  out  TAG_W  tag of this product

## Operation
- Operands are extended by 2 bits: sign-extend if in_signed=1, zero-extend if 0. NPP = WIDTH/2 + 1 Booth digits.
- Digit i is taken from extended in_b bits [2i+1:2i-1], with bit -1 = 0. Encoding: 0, +1, +2, -1, -2. Negative digits use inverted PP plus a +1 correction bit at column 2i. The correction bits go into the tree as an extra row.
- Each PP is sign-extended to 2*WIDTH+2 bits. All arithmetic is mod 2^(2*WIDTH+2). out_p is the low 2*WIDTH bits.
- Stage 1 (S1): Booth recode and form PPs; register PPs, correction row, signed flag and tag.
- Stage 2 (S2): 3:2 CSA rows reduce NPP+1 rows to 2 rows; register sum/carry and tag.
- Stage 3 (S3): carry-propagate add; register out_p and out_tag.
- Each stage has a valid bit. Stage k loads when its upstream stage is valid and (stage k is empty or stage k advances this cycle).
- in_ready = !S1_valid | S1 advances. out_valid = S3_valid. S3 clears on out_ready with no new load.
- Data registers update only on load. No bubble is inserted on simultaneous load and unload.

## Timing
- Latency: a transfer at cycle t (in_valid & in_ready) gives out_valid at t+3, when the pipe is empty and out_ready=1.
- Throughput: 1 result/cycle with out_ready held high.
- Backpressure: while out_valid & !out_ready, out_p and out_tag hold stable. The pipeline fills up to 3 items, then in_ready=0. in_ready is combinational from out_ready.
- Handshake rules:
  - out_valid never drops without a transfer.
  - in_valid/data must hold until accepted. The block does not depend on this for correctness.
- Reset values: all valid bits 0, in_ready 1 after reset deasserts, out_valid 0, out_p 0, out_tag 0. Sum/carry/PP registers are cleared to 0.
- Reset mid-operation: all in-flight items are discarded and no partial output is produced. The first post-reset accept follows the normal latency.

## Structure
- Package booth_pkg:
  - Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2).
  - Function booth_npp(WIDTH) returning WIDTH/2+1.
  - Localparam for extended width (2*WIDTH+2).
- Sub-module csa_row, parametrised N: bitwise 3:2 compressor row with sum[N] and carry[N] outputs. The caller shifts carry left by 1. The S2 tree is generated from csa_row instances.
- Top module holds recode, stage registers, handshake and the final adder (inferred +).

## Test plan
- WIDTH=16, signed: a=0x8000, b=0x8000 → out_p=0x4000_0000. a=0xFFFF, b=0x0001 → 0xFFFF_FFFF. a=0x7FFF, b=0x8000 → 0xC000_8000.
- WIDTH=16, unsigned: a=0xFFFF, b=0xFFFF → 0xFFFE_0001. a=0x8000, b=0x0002 → 0x0001_0000. a=0, b=0x1234 → 0.
- Streaming: 100 random back-to-back ops with mixed in_signed and out_ready=1. Expect first out_valid 3 cycles after first accept, one result/cycle, and tags in order.
- Backpressure: out_ready=0 for 5 cycles during a stream. Expect out_p/out_tag stable, in_ready=0 after 3 items buffered, and no loss or duplication when out_ready returns.
- Reset: assert rst with 3 items in flight. Expect out_valid=0 immediately (async), in_ready=1 after release, and the next op returns correctly after 3 cycles.
- Parameter sweep: WIDTH=4,8,32 exhaustive (WIDTH=4,8) or random (WIDTH=32) against a behavioural reference in both modes.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_e;

  localparam int BOOTH_WIDTH_DEF = 16;
  localparam int BOOTH_EXT_W_DEF = 2 * BOOTH_WIDTH_DEF + 2;

  function automatic int booth_npp(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int booth_ext_w(input int width);
    return 2 * width + 2;
  endfunction

  // Overlapping triplet {b[2i+1], b[2i], b[2i-1]} selects the digit.
  function automatic booth_digit_e booth_decode(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/csa_row.sv
// Bitwise 3:2 compressor row; the caller aligns carry one column to the left.
module csa_row #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [N-1:0] i_c,
  output logic [N-1:0] o_sum,
  output logic [N-1:0] o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/booth_mult_pipe.sv
// Three-stage radix-4 Booth multiplier: recode/PP, carry-save reduction, final add.
module booth_mult_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NPP   = booth_npp(WIDTH);
  localparam int EXT_W = booth_ext_w(WIDTH);
  localparam int OPW   = WIDTH + 2;

  logic signed [OPW-1:0]   w_a_ext;
  logic signed [OPW-1:0]   w_b_ext;
  logic signed [EXT_W-1:0] w_a_sx;
  logic [OPW:0]            w_b_pad;
  logic [EXT_W-1:0]        w_pp [NPP];
  logic [EXT_W-1:0]        w_corr;

  logic                    w_ld1, w_ld2, w_ld3;

  logic [EXT_W-1:0]        r_pp_p0 [NPP];
  logic [EXT_W-1:0]        r_corr_p0;
  logic [TAG_W-1:0]        r_tag_p0;
  logic                    r_vld_p0;

  logic [EXT_W-1:0]        w_rows [NPP+1];
  logic [EXT_W-1:0]        w_sum  [NPP];
  logic [EXT_W-1:0]        w_car  [NPP];
  logic [EXT_W-1:0]        w_craw [NPP-1];

  logic [EXT_W-1:0]        r_sum_p1;
  logic [EXT_W-1:0]        r_car_p1;
  logic [TAG_W-1:0]        r_tag_p1;
  logic                    r_vld_p1;

  logic [1:0]              w_cpa_unused;
  logic [2*WIDTH-1:0]      w_cpa;

  logic [2*WIDTH-1:0]      r_p_p2;
  logic [TAG_W-1:0]        r_tag_p2;
  logic                    r_vld_p2;

  // Handshake: each stage loads when upstream is valid and it is empty or draining.
  assign w_ld3    = r_vld_p1 & (~r_vld_p2 | out_ready);
  assign w_ld2    = r_vld_p0 & (~r_vld_p1 | w_ld3);
  assign w_ld1    = in_valid & (~r_vld_p0 | w_ld2);
  assign in_ready = ~r_vld_p0 | w_ld2;

  assign w_a_ext = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
  assign w_b_ext = {{2{in_signed & in_b[WIDTH-1]}}, in_b};
  assign w_a_sx  = {{(EXT_W-OPW){w_a_ext[OPW-1]}}, w_a_ext};
  assign w_b_pad = {w_b_ext, 1'b0};

  // S1: Booth recode; negatives are ~m << 2i with the +1 deferred to the correction row.
  always_comb begin
    booth_digit_e v_dig;
    v_dig  = ZERO;
    w_pp   = '{default: '0};
    w_corr = '0;
    for (int i = 0; i < NPP; i++) begin
      v_dig = booth_decode(w_b_pad[2*i+2 -: 3]);
      case (v_dig)
        POS1:    w_pp[i] = w_a_sx << (2*i);
        POS2:    w_pp[i] = w_a_sx << (2*i+1);
        NEG1:    w_pp[i] = (~w_a_sx) << (2*i);
        NEG2:    w_pp[i] = (~(w_a_sx << 1)) << (2*i);
        default: w_pp[i] = '0;
      endcase
      w_corr[2*i] = (v_dig == NEG1) || (v_dig == NEG2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pp_p0   <= '{default: '0};
      r_corr_p0 <= '0;
      r_tag_p0  <= '0;
      r_vld_p0  <= 1'b0;
    end else begin
      if (w_ld1) begin
        r_pp_p0   <= w_pp;
        r_corr_p0 <= w_corr;
        r_tag_p0  <= in_tag;
      end
      if (w_ld1)      r_vld_p0 <= 1'b1;
      else if (w_ld2) r_vld_p0 <= 1'b0;
    end
  end

  // S2: chain of 3:2 rows folds NPP partial products plus the correction row into sum/carry.
  always_comb begin
    for (int i = 0; i < NPP; i++) w_rows[i] = r_pp_p0[i];
    w_rows[NPP] = r_corr_p0;
  end

  assign w_sum[0] = w_rows[0];
  assign w_car[0] = w_rows[1];

  for (genvar k = 0; k < NPP - 1; k++) begin : g_csa
    csa_row #(.N(EXT_W)) u_csa (
      .i_a     (w_sum[k]),
      .i_b     (w_car[k]),
      .i_c     (w_rows[k+2]),
      .o_sum   (w_sum[k+1]),
      .o_carry (w_craw[k])
    );
    assign w_car[k+1] = w_craw[k] << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_p1 <= '0;
      r_car_p1 <= '0;
      r_tag_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      if (w_ld2) begin
        r_sum_p1 <= w_sum[NPP-1];
        r_car_p1 <= w_car[NPP-1];
        r_tag_p1 <= r_tag_p0;
      end
      if (w_ld2)      r_vld_p1 <= 1'b1;
      else if (w_ld3) r_vld_p1 <= 1'b0;
    end
  end

  // S3: carry-propagate add; the two guard bits above the product are discarded.
  assign {w_cpa_unused, w_cpa} = r_sum_p1 + r_car_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_p2   <= '0;
      r_tag_p2 <= '0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_ld3) begin
        r_p_p2   <= w_cpa;
        r_tag_p2 <= r_tag_p1;
      end
      if (w_ld3)          r_vld_p2 <= 1'b1;
      else if (out_ready) r_vld_p2 <= 1'b0;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_p     = r_p_p2;
  assign out_tag   = r_tag_p2;

endmodule
